// File: rtl/alu_nibble_serial.sv
// Nibble-serial 65xx ALU: ADC/SBC resolve one binary/BCD digit per clock through a
// single 4-bit adder; ORA/AND/EOR/ROR/PSA complete on the accepting edge.

`ifndef ALU_ORA
`define ALU_ORA 4'h0
`define ALU_AND 4'h1
`define ALU_EOR 4'h2
`define ALU_ADC 4'h3
`define ALU_SBC 4'h4
`define ALU_ROR 4'h5
`define ALU_PSA 4'h6
`endif

module alu_nibble_serial #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               c_in,
    input  logic               dec,
    output logic               ready,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               carry_out,
    output logic               half_carry_out,
    output logic               overflow_out,
    output logic               zero_out,
    output logic               neg_out,
    output logic [WIDTH/4-1:0] digit_carry
);

    localparam int DIGITS = WIDTH / 4;
    localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_next;

    logic             accept, in_arith, in_sbc;
    logic [WIDTH-1:0] b_eff;

    // Operands are held right-shifted so the active digit always sits in bits [3:0].
    logic [WIDTH-1:0] a_q, b_q;
    logic             sbc_q, dec_q, carry_q;
    logic [KW-1:0]    k_q;

    logic [KW-1:0]     dig_k;
    logic [3:0]        dig_a, dig_b, r;
    logic              dig_cin, dig_dec, dig_sbc;
    logic [4:0]        t;
    logic              cout, last_digit, arith_step, v_next;
    logic [WIDTH-1:0]  arith_result;
    logic [DIGITS-1:0] dc_next;
    logic [WIDTH-1:0]  logic_result;
    logic              logic_carry;

    assign ready      = (state != RUN);
    assign done       = (state == DONE);
    assign accept     = start && ready;
    assign in_sbc     = (op == `ALU_SBC);
    assign in_arith   = (op == `ALU_ADC) || in_sbc;
    assign b_eff      = in_sbc ? ~b : b;
    assign arith_step = (accept && in_arith) || (state == RUN);

    // Digit 0 comes straight from the ports on the accepting edge; later digits from the latches.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and give every output a value on every path, so no latches are inferred.
        dig_k   = '0;
        dig_a   = a[3:0];
        dig_b   = b_eff[3:0];
        dig_cin = c_in;
        dig_dec = dec;
        dig_sbc = in_sbc;
        if (state == RUN) begin
            dig_k   = k_q;
            dig_a   = a_q[3:0];
            dig_b   = b_q[3:0];
            dig_cin = carry_q;
            dig_dec = dec_q;
            dig_sbc = sbc_q;
        end
    end

    always_comb begin
        t    = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0, dig_cin};
        r    = t[3:0];
        cout = t[4];
        if (dig_dec) begin
            if (!dig_sbc) begin
                cout = (t > 5'd9);
                if (cout) r = t[3:0] + 4'd6;
            end else if (!t[4]) begin
                r = t[3:0] + 4'd10;
            end
        end
        last_digit = (dig_k == LAST_K);
        // V uses the pre-adjust sum of the top digit, as the NMOS part does.
        v_next       = (dig_a[3] == dig_b[3]) && (dig_a[3] != t[3]);
        arith_result = WIDTH'({r, result} >> 4);
        dc_next      = DIGITS'({cout, digit_carry} >> 1);
    end

    always_comb begin
        logic_result = a;
        logic_carry  = 1'b0;
        case (op)
            `ALU_ORA: logic_result = a | b;
            `ALU_AND: begin
                logic_result = a & b;
                logic_carry  = |(a & b);
            end
            `ALU_EOR: logic_result = a ^ b;
            `ALU_ROR: begin
                logic_result = {c_in, a[WIDTH-1:1]};
                logic_carry  = a[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_next = (in_arith && !last_digit) ? RUN : DONE;
                else if (state == DONE)
                    state_next = IDLE;
            end
            RUN:     if (last_digit) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: operand latches are reset along with the outputs so an aborted op leaves no stale state behind.
            a_q            <= '0;
            b_q            <= '0;
            sbc_q          <= 1'b0;
            dec_q          <= 1'b0;
            carry_q        <= 1'b0;
            k_q            <= '0;
            result         <= '0;
            carry_out      <= 1'b0;
            half_carry_out <= 1'b0;
            overflow_out   <= 1'b0;
            zero_out       <= 1'b0;
            neg_out        <= 1'b0;
            digit_carry    <= '0;
        end else begin
            if (accept) begin
                a_q   <= a >> 4;
                b_q   <= b_eff >> 4;
                sbc_q <= in_sbc;
                dec_q <= dec;
            end else if (state == RUN) begin
                a_q <= a_q >> 4;
                b_q <= b_q >> 4;
            end

            if (arith_step) begin
                // Result and digit carries shift in from the top; after DIGITS steps each digit is in place.
                result      <= arith_result;
                digit_carry <= dc_next;
                carry_q     <= cout;
                k_q         <= dig_k + 1'b1;
                if (last_digit) begin
                    carry_out      <= cout;
                    half_carry_out <= dc_next[0];
                    overflow_out   <= v_next;
                    zero_out       <= (arith_result == '0);
                    neg_out        <= arith_result[WIDTH-1];
                end
            end else if (accept) begin
                result         <= logic_result;
                carry_out      <= logic_carry;
                half_carry_out <= 1'b0;
                overflow_out   <= 1'b0;
                digit_carry    <= '0;
                zero_out       <= (logic_result == '0);
                neg_out        <= logic_result[WIDTH-1];
            end
        end
    end

endmodule

// File: doc/alu_nibble_serial.md
# alu_nibble_serial

Parametrised, nibble-serial ALU for the 65xx datapath family. Processes ADC/SBC one 4-bit digit per clock with per-digit decimal adjust, so wider datapaths (16/24/32-bit) reuse a single nibble adder. ORA/AND/EOR/ROR/PSA complete in one cycle. Sits behind the operand input muxes; the sequencer drives it through a start/ready/done handshake.

## Interface
- WIDTH, 8, operand width in bits; must be a multiple of 4 and at least 4; DIGITS = WIDTH/4
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; accepted on an edge where start=1 and ready=1
- op  in  4  operation, encoded with the shared `ALU_ORA/AND/EOR/ADC/SBC/ROR/PSA` defines
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; the block inverts b internally for SBC
- c_in  in  1  carry in (borrow-not for SBC; rotate-in bit for ROR)
- dec  in  1  decimal mode for ADC/SBC; ignored for all other ops
- ready  out  1  high when a start can be accepted (state != RUN)
- done  out  1  one-cycle pulse: the result and flags have just updated
- result  out  WIDTH  registered result
- carry_out, half_carry_out, overflow_out, zero_out, neg_out  out  1 each  registered flags
- digit_carry  out  DIGITS  registered carry out of each digit (ADC/SBC only)

## Operation
- States: IDLE, RUN, DONE.
- At start acceptance the block latches op, a, b' (b' = ~b for SBC, else b), c_in and dec.
- ADC/SBC go to RUN with digit index k=0. All other ops compute in the same edge and go to DONE.
- RUN, one digit per edge, with t = a[k] + b'[k] + carry (5 bits) and carry = c_in for k=0:
  - Binary: r = t[3:0], cout = t[4].
  - Decimal ADC: if t > 9 then r = (t+6)[3:0] and cout = 1; else r = t[3:0] and cout = 0.
  - Decimal SBC: cout = t[4]; r = t[3:0] if cout=1, else (t+10)[3:0].
  - r is written to result digit k; cout is stored to digit_carry[k] and the carry register.
  - After digit DIGITS-1: state goes to DONE. Flags:
    - carry_out = final cout
    - half_carry_out = digit_carry[0]
    - overflow_out = (a[W-1] == b'[W-1]) && (a[W-1] != unadjusted t[3] of the top digit); uses the NMOS rule, so decimal V comes from the pre-adjust sum
- Single-cycle ops (overflow_out and digit_carry are cleared for these):
  - ORA: result = a|b, carry_out = 0.
  - AND: result = a&b, carry_out = |result (used for bit tests).
  - EOR: result = a^b, carry_out = 0.
  - ROR: {result, carry_out} = {c_in, a}.
  - PSA: result = a, carry_out = 0.
- zero_out = (result == 0); neg_out = result[WIDTH-1]. Both are computed from the final result.
- DONE: done=1 for exactly one cycle. Then IDLE, or a new op if start was accepted in DONE (back-to-back).
- Outputs hold their values until the next op completes. Intermediate digits are not guaranteed stable before done.
- Any undefined op behaves as PSA.

## Timing
- Reset values:
  - state = IDLE
  - ready = 1, done = 0
  - result = 0
  - all flags = 0, digit_carry = 0
- Latency, counted from the accepting edge to the edge where done rises:
  - single-cycle ops: 1
  - ADC/SBC: DIGITS (8-bit: 2, 32-bit: 8)
- ready = 0 throughout RUN. A start during RUN is ignored, with no queueing.
- A start in DONE is accepted; its op begins while done is high for the previous op.
- Throughput, back-to-back: 1 op/cycle for single-cycle ops; one ADC/SBC per DIGITS cycles.
- Reset asserted mid-RUN: the next edge goes to IDLE and clears all outputs. No done pulse appears for the aborted op.
- reset has priority over start on the same edge.

## Test plan
- WIDTH=8, ADC, dec=1, a=0x58, b=0x46, c_in=0 -> done 2 cycles after start; result=0x04, C=1, half_carry=1, Z=0, V=1.
- WIDTH=8, SBC, dec=1, a=0x46, b=0x12, c_in=1 -> 0x34, C=1. Then a=0x00, b=0x01, c_in=1 -> 0x99, C=0, N=1.
- WIDTH=16, ADC, dec=0, a=0x7FFF, b=0x0001, c_in=0 -> done after 4 cycles, ready low for 3; result=0x8000, V=1, N=1, C=0, digit_carry=4'b0111.
- WIDTH=8, back-to-back ROR a=0x01 c_in=1, then AND a=0xF0 b=0x0F -> first op: 0x80, C=1 at cycle 1; second op: 0x00, C=0, Z=1 at cycle 2.
- WIDTH=32, ADC started, reset asserted at cycle 3 -> all outputs 0, ready=1, and no done pulse. A start asserted at cycle 2 of an ADC is ignored, and the result equals the original op's.
- Sweep at WIDTH=8, dec=1, ADC and SBC over all valid BCD a and b, and c_in ∈ {0,1} -> result, C and V match the golden NMOS 6502 model.
